// File: rtl/cbp_seq_divider_pkg.sv
// Shared types and constants for the sequential carry-bypass divider.
// Build option: CBP_DIV_SIGNED_EN enables signed divide (SIGN state, overflow flag).
package cbp_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int BYP_GRP_W  = 4;

  typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} div_state_e;

endpackage

// File: rtl/cbp_seq_divider_if.sv
// Start/busy/done handshake between the issuing controller (master) and the divider (slave).
interface cbp_seq_divider_if
  import cbp_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic              start;
  logic              signed_op;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;
  logic              overflow;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/cbp_seq_divider_addsub.sv
// DATA_W adder/subtractor built from 4-bit ripple groups with a carry bypass per group.
// sub=1 computes a + ~b + 1; DATA_W must be a multiple of the group width.
module cbp_addsub
  import cbp_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);
  localparam int NGRP = DATA_W / BYP_GRP_W;

  logic [DATA_W-1:0] bx;
  logic [DATA_W-1:0] p;

  assign bx = b ^ {DATA_W{sub}};
  assign p  = a ^ bx;

  always_comb begin
    logic c;
    logic gc;
    sum = '0;
    gc  = sub;
    for (int g = 0; g < NGRP; g++) begin
      c = gc;
      for (int i = 0; i < BYP_GRP_W; i++) begin
        sum[g*BYP_GRP_W+i] = p[g*BYP_GRP_W+i] ^ c;
        c = (a[g*BYP_GRP_W+i] & bx[g*BYP_GRP_W+i]) | (p[g*BYP_GRP_W+i] & c);
      end
      // A fully propagating group passes its carry-in straight through.
      gc = (&p[g*BYP_GRP_W +: BYP_GRP_W]) ? gc : c;
    end
    cout = gc;
  end
endmodule

// File: rtl/cbp_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock through a carry-bypass subtractor.
// Build option: CBP_DIV_SIGNED_EN adds signed divide via a magnitude pass plus a SIGN fix-up state.
module cbp_seq_divider
  import cbp_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input logic              clk,
  input logic              rst_n,
  cbp_seq_divider_if.slave dif
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rmd_q, rmd_d;
  logic              dbz_q, dbz_d;

  logic              accept, div_zero, sgn_act, take, add_co;
  logic [DATA_W-1:0] shifted, add_a, add_b, add_s;

`ifdef CBP_DIV_SIGNED_EN
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  logic sgn_q, sgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;
  assign sgn_act = sgn_q;
`else
  logic unused_signed_op;
  assign unused_signed_op = dif.signed_op;
  assign sgn_act = 1'b0;
`endif

  assign accept   = dif.start && (state_q == IDLE || state_q == DONE);
  assign div_zero = (dif.divisor == '0);
  // rem_q[MSB] is the 33rd bit of the shifted partial remainder.
  assign shifted  = {rem_q[DATA_W-2:0], acc_q[DATA_W-1]};
  assign take     = rem_q[DATA_W-1] | add_co;

  always_comb begin
    add_a = shifted;
    add_b = dvs_q;
    if (state_q == SIGN) begin
      add_a = '0;
      add_b = rem_q;
    end
  end

  cbp_addsub #(.DATA_W(DATA_W)) u_addsub (
    .a(add_a), .b(add_b), .sub(1'b1), .sum(add_s), .cout(add_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dif.start) state_d = div_zero ? DONE : ITER;
      ITER:    if (cnt_q == LAST_STEP) state_d = sgn_act ? SIGN : DONE;
      SIGN:    state_d = DONE;
      DONE:    state_d = dif.start ? (div_zero ? DONE : ITER) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dif.busy        = (state_q == ITER) || (state_q == SIGN);
    dif.done        = (state_q == DONE);
    dif.quotient    = quo_q;
    dif.remainder   = rmd_q;
    dif.div_by_zero = dbz_q;
`ifdef CBP_DIV_SIGNED_EN
    dif.overflow    = ovf_q;
`else
    dif.overflow    = 1'b0;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    acc_d = acc_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
`ifdef CBP_DIV_SIGNED_EN
    sgn_d      = sgn_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif
    if (accept) begin
      cnt_d = '0;
      rem_d = '0;
      acc_d = dif.dividend;
      dvs_d = dif.divisor;
`ifdef CBP_DIV_SIGNED_EN
      sgn_d      = dif.signed_op;
      neg_quo_d  = dif.signed_op & (dif.dividend[DATA_W-1] ^ dif.divisor[DATA_W-1]);
      neg_rem_d  = dif.signed_op & dif.dividend[DATA_W-1];
      ovf_pend_d = dif.signed_op && (dif.dividend == MIN_VAL) && (&dif.divisor);
      if (dif.signed_op) begin
        // Divide magnitudes; MIN stays MIN, which is its correct unsigned magnitude.
        acc_d = dif.dividend[DATA_W-1] ? -dif.dividend : dif.dividend;
        dvs_d = dif.divisor[DATA_W-1]  ? -dif.divisor  : dif.divisor;
      end
      if (div_zero) ovf_d = 1'b0;
`endif
      if (div_zero) begin
        quo_d = '1;
        rmd_d = dif.dividend;
        dbz_d = 1'b1;
      end
    end else if (state_q == ITER) begin
      cnt_d = cnt_q + CNT_W'(1);
      rem_d = take ? add_s : shifted;
      acc_d = {acc_q[DATA_W-2:0], take};
      if (cnt_q == LAST_STEP && !sgn_act) begin
        quo_d = acc_d;
        rmd_d = rem_d;
        dbz_d = 1'b0;
`ifdef CBP_DIV_SIGNED_EN
        ovf_d = 1'b0;
`endif
      end
    end
`ifdef CBP_DIV_SIGNED_EN
    else if (state_q == SIGN) begin
      quo_d = neg_quo_q ? -acc_q : acc_q;
      rmd_d = neg_rem_q ? add_s : rem_q;
      dbz_d = 1'b0;
      ovf_d = ovf_pend_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      acc_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
`ifdef CBP_DIV_SIGNED_EN
      sgn_q      <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      acc_q <= acc_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
`ifdef CBP_DIV_SIGNED_EN
      sgn_q      <= sgn_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_cbp_seq_divider.sv
// Self-checking bench: transaction-level reference model, per-cycle compare, directed + random ops.
module tb_cbp_seq_divider;
  localparam int W = 32;
`ifdef CBP_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cbp_seq_divider_if #(.DATA_W(W)) dif();
  cbp_seq_divider #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .dif(dif));

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  int n_chk = 0;
  int n_pass = 0;

  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t o;
    o = '0;
    if (b == '0) begin
      o.q = '1; o.r = a; o.dbz = 1'b1;
    end else if (SIGNED_EN && s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      o.q = a; o.r = '0; o.ovf = 1'b1;
    end else if (SIGNED_EN && s) begin
      o.q = $signed(a) / $signed(b);
      o.r = $signed(a) % $signed(b);
    end else begin
      o.q = a / b;
      o.r = a % b;
    end
    return o;
  endfunction

  // Cycle number of done, counting the cycle that presents start as cycle 0.
  function automatic int ref_lat(input logic [W-1:0] b, input logic s);
    if (b == '0) return 1;
    if (SIGNED_EN && s) return W + 2;
    return W + 1;
  endfunction

  // Reference model: one pending op, its done edge, and the results currently on the outputs.
  int   edge_n = 0;
  int   dn_edge = 0;
  int   last_done = -1;
  bit   pend = 1'b0;
  res_t exp_r = '0;
  res_t held = '0;

  always @(posedge clk) begin
    bit can_acc;
    edge_n++;
    if (!rst_n) begin
      pend = 1'b0; held = '0; last_done = -1;
    end else begin
      can_acc = !(pend && dn_edge >= edge_n);
      if (pend && dn_edge == edge_n) begin
        held = exp_r; last_done = edge_n; pend = 1'b0;
      end
      if (dif.start && can_acc) begin
        exp_r   = ref_div(dif.dividend, dif.divisor, dif.signed_op);
        dn_edge = edge_n + ref_lat(dif.divisor, dif.signed_op) - 1;
        pend    = 1'b1;
        if (dn_edge == edge_n) begin
          held = exp_r; last_done = edge_n; pend = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    res_t got;
    if (edge_n > 0) begin
      got = {dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow};
      n_chk++;
      if (dif.busy === pend && dif.done === (last_done == edge_n) && got === held)
        n_pass++;
      else
        $display("FAIL cycle edge=%0d: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, want busy=%b done=%b q=%h r=%h dbz=%b ovf=%b",
                 edge_n, dif.busy, dif.done, got.q, got.r, got.dbz, got.ovf,
                 pend, (last_done == edge_n), held.q, held.r, held.dbz, held.ovf);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  // Issues one op; poke>=0 pulses a stray start (8/2) that many cycles after acceptance.
  // now=1 drives start in the current cycle (back-to-back from a done cycle).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit now, input int poke, output int lat);
    int acc;
    if (!now) @(negedge clk);
    dif.start = 1'b1; dif.dividend = a; dif.divisor = b; dif.signed_op = s;
    @(negedge clk);
    acc = edge_n;
    dif.start = 1'b0; dif.dividend = $urandom; dif.divisor = $urandom; dif.signed_op = $urandom;
    lat = -1;
    for (int k = 0; k < W + 8; k++) begin
      if (dif.done) begin
        lat = edge_n - acc + 1;
        break;
      end
      dif.start = (k == poke);
      if (k == poke) begin dif.dividend = 8; dif.divisor = 2; end
      @(negedge clk);
    end
    dif.start = 1'b0;
    if (lat < 0) begin
      n_chk++;
      $display("FAIL timeout: no done within %0d cycles for %h/%h", W + 8, a, b);
    end
  endtask

  function automatic logic [W-1:0] rnd_dividend();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return W'($urandom_range(0, 300));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_divisor();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'($urandom_range(1, 15));
      2:       return W'($urandom) | 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int   lat;
    int   nd;
    res_t m;
    dif.start = 1'b0; dif.signed_op = 1'b0; dif.dividend = '0; dif.divisor = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", dif.busy, 0);
    chk("reset done", dif.done, 0);
    chk("reset quotient", dif.quotient, 0);
    chk("reset remainder/flags", {dif.remainder, dif.div_by_zero, dif.overflow}, 0);
    rst_n = 1'b1;

    m = ref_div(100, 7, 1'b0);
    chk("model 100/7", {m.q, m.r}, {32'd14, 32'd2});
    m = ref_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    chk("model rem_hi", {m.q, m.r}, {32'd1, 32'h7FFF_FFFE});
    chk("model lat 100/7", ref_lat(7, 1'b0), 33);

    run_op(100, 7, 1'b0, 1'b0, -1, lat);
    chk("100/7 latency", lat, 33);
    chk("100/7 q,r", {dif.quotient, dif.remainder}, {32'd14, 32'd2});
    chk("100/7 flags", {dif.div_by_zero, dif.overflow}, 0);

    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, -1, lat);
    chk("rem_hi q,r", {dif.quotient, dif.remainder}, {32'd1, 32'h7FFF_FFFE});

    run_op(5, 0, 1'b0, 1'b0, -1, lat);
    chk("5/0 latency", lat, 1);
    chk("5/0 q,r", {dif.quotient, dif.remainder}, {32'hFFFF_FFFF, 32'd5});
    chk("5/0 dbz", dif.div_by_zero, 1);

    run_op(9, 3, 1'b0, 1'b0, -1, lat);
    chk("9/3 q,r,dbz", {dif.quotient, dif.remainder, dif.div_by_zero}, {32'd3, 32'd0, 1'b0});

    run_op(100, 7, 1'b0, 1'b0, 10, lat);
    chk("start-while-busy latency", lat, 33);
    chk("start-while-busy q,r", {dif.quotient, dif.remainder}, {32'd14, 32'd2});

    run_op(12345, 100, 1'b0, 1'b1, -1, lat);
    chk("back-to-back latency", lat, 33);
    chk("back-to-back q,r", {dif.quotient, dif.remainder}, {32'd123, 32'd45});

    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 100; dif.divisor = 7; dif.signed_op = 1'b0;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort outputs", {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow}, 0);
    nd = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (dif.done) nd++;
    end
    chk("abort no done", nd, 0);

    run_op(100, 7, 1'b0, 1'b0, -1, lat);
    chk("post-reset 100/7", {dif.quotient, dif.remainder, 32'(lat)}, {32'd14, 32'd2, 32'd33});

`ifdef CBP_DIV_SIGNED_EN
    run_op(-32'sd7, 32'd2, 1'b1, 1'b0, -1, lat);
    chk("signed -7/2 latency", lat, 34);
    chk("signed -7/2 q,r", {dif.quotient, dif.remainder}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, lat);
    chk("MIN/-1 q,r,ovf", {dif.quotient, dif.remainder, dif.overflow}, {32'h8000_0000, 32'd0, 1'b1});
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      dif.start     = ($urandom_range(0, 9) == 0);
      dif.signed_op = $urandom;
      dif.dividend  = rnd_dividend();
      dif.divisor   = rnd_divisor();
      rst_n         = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    dif.start = 1'b0;
    rst_n = 1'b1;
    repeat (W + 8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
